// File: rtl/sum_series_tx.sv
// Series transmitter for the summing accumulator: emits a framed arithmetic series,
// keeps a reference sum, and checks the accumulator result with pass/fail counters.
module sum_series_tx #(
    parameter int NOF_BITS = 32,
    parameter int LEN_BITS = 8,
    parameter int TIMEOUT  = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [LEN_BITS-1:0] len,
    input  logic [NOF_BITS-1:0] base,
    input  logic [NOF_BITS-1:0] step,
    output logic                data_first,
    output logic                data_last,
    output logic [NOF_BITS-1:0] data_out,
    input  logic                sum_done,
    input  logic [NOF_BITS:0]   sum_result,
    output logic                ready,
    output logic                check_valid,
    output logic                check_ok,
    output logic                timeout,
    output logic [15:0]         pass_cnt,
    output logic [15:0]         fail_cnt
);

    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, SEND, WAIT} state_t;

    state_t              state, state_nxt;
    logic [LEN_BITS-1:0] len_r;
    logic [LEN_BITS-1:0] idx;
    logic [LEN_BITS-1:0] idx_nxt;
    logic [LEN_BITS-1:0] len_m1;
    logic [NOF_BITS-1:0] step_r;
    logic [NOF_BITS:0]   ref_sum;
    logic [TW-1:0]       tcnt;
    logic                accept;
    logic                last_word;
    logic                tmo_hit;

    function automatic logic [15:0] sat_inc(input logic [15:0] c);
        return (c == 16'hFFFF) ? c : c + 16'd1;
    endfunction

    always_comb begin
        accept    = (state == IDLE) && start && (len != '0);
        idx_nxt   = idx + 1'b1;
        len_m1    = len_r - 1'b1;
        last_word = (idx == len_m1);
        tmo_hit   = (tcnt == TW'(TIMEOUT - 1));
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = SEND;
            SEND:    if (last_word) state_nxt = WAIT;
            WAIT:    if (sum_done || tmo_hit) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Every output is a register; the data path clears whenever SEND is not active.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            ready       <= 1'b1;
            data_first  <= 1'b0;
            data_last   <= 1'b0;
            data_out    <= '0;
            len_r       <= '0;
            idx         <= '0;
            step_r      <= '0;
            ref_sum     <= '0;
            tcnt        <= '0;
            check_valid <= 1'b0;
            check_ok    <= 1'b0;
            timeout     <= 1'b0;
            pass_cnt    <= '0;
            fail_cnt    <= '0;
        end else begin
            state       <= state_nxt;
            ready       <= (state_nxt == IDLE);
            check_valid <= 1'b0;
            data_first  <= 1'b0;
            data_last   <= 1'b0;
            data_out    <= '0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        len_r      <= len;
                        step_r     <= step;
                        idx        <= '0;
                        ref_sum    <= '0;
                        data_out   <= base;
                        data_first <= 1'b1;
                        data_last  <= (len == LEN_BITS'(1));
                    end
                end
                SEND: begin
                    ref_sum <= ref_sum + {1'b0, data_out};
                    if (!last_word) begin
                        idx       <= idx_nxt;
                        data_out  <= data_out + step_r;
                        data_last <= (idx_nxt == len_m1);
                    end else begin
                        tcnt <= '0;
                    end
                end
                WAIT: begin
                    // A done arriving on the last allowed cycle still counts as a real check.
                    if (sum_done) begin
                        check_valid <= 1'b1;
                        check_ok    <= (sum_result == ref_sum);
                        timeout     <= 1'b0;
                        if (sum_result == ref_sum) pass_cnt <= sat_inc(pass_cnt);
                        else                       fail_cnt <= sat_inc(fail_cnt);
                    end else if (tmo_hit) begin
                        check_valid <= 1'b1;
                        check_ok    <= 1'b0;
                        timeout     <= 1'b1;
                        fail_cnt    <= sat_inc(fail_cnt);
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sum_series_tx.sv
// Scoreboard bench for sum_series_tx: the stimulus plays the accumulator and queues
// expected words and check results; a negedge monitor pops and compares them.
module tb_sum_series_tx;
    localparam int NB  = 8;
    localparam int LB  = 8;
    localparam int TMO = 16;

    logic          clk = 0;
    logic          rst_n = 0;
    logic          start = 0;
    logic [LB-1:0] len = 0;
    logic [NB-1:0] base = 0, step = 0;
    logic          data_first, data_last;
    logic [NB-1:0] data_out;
    logic          sum_done = 0;
    logic [NB:0]   sum_result = 0;
    logic          ready, check_valid, check_ok, timeout;
    logic [15:0]   pass_cnt, fail_cnt;

    sum_series_tx #(.NOF_BITS(NB), .LEN_BITS(LB), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .len(len), .base(base), .step(step),
        .data_first(data_first), .data_last(data_last), .data_out(data_out),
        .sum_done(sum_done), .sum_result(sum_result), .ready(ready),
        .check_valid(check_valid), .check_ok(check_ok), .timeout(timeout),
        .pass_cnt(pass_cnt), .fail_cnt(fail_cnt)
    );

    always #5 clk = ~clk;

    typedef struct { logic [NB-1:0] d; logic f; logic l; } word_t;
    typedef struct { logic ok; logic to; logic [15:0] pc; logic [15:0] fc; } chk_t;

    word_t wq[$];
    chk_t  cq[$];
    bit    in_ser = 0;
    int    checks = 0, fails = 0;
    int    m_pass = 0, m_fail = 0;
    word_t w;
    chk_t  c;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endfunction

    // Monitor: series words are framed by data_first..data_last, checks by check_valid.
    always @(negedge clk) begin
        if (!rst_n) begin
            wq.delete();
            in_ser = 0;
        end else begin
            if (in_ser || data_first) begin
                if (wq.size() == 0) begin
                    chk("word_unexpected", {data_first, data_last, 22'd0, data_out}, 32'd0);
                    in_ser = 0;
                end else begin
                    w = wq.pop_front();
                    chk("word", {data_first, data_last, 22'd0, data_out}, {w.f, w.l, 22'd0, w.d});
                    in_ser = !w.l;
                end
            end else if (data_first || data_last || data_out != '0) begin
                chk("idle_quiet", {data_first, data_last, 22'd0, data_out}, 32'd0);
            end
            if (check_valid) begin
                if (cq.size() == 0) begin
                    chk("check_unexpected", 32'd1, 32'd0);
                end else begin
                    c = cq.pop_front();
                    chk("check_ok", {31'd0, check_ok}, {31'd0, c.ok});
                    chk("check_timeout", {31'd0, timeout}, {31'd0, c.to});
                    chk("counters", {pass_cnt, fail_cnt}, {c.pc, c.fc});
                end
            end
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (!ready && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (!ready) chk("ready_wait", 32'd0, 32'd1);
    endtask

    // exp_ok and result are hand-computed by the caller.
    task automatic run_series(input int l, input logic [NB-1:0] b, input logic [NB-1:0] s,
                              input logic [NB:0] res, input bit do_done, input bit exp_ok,
                              input bit inject);
        logic [NB-1:0] v = b;
        wait_ready();
        for (int k = 0; k < l; k++) begin
            wq.push_back('{d: v, f: (k == 0), l: (k == l - 1)});
            v = v + s;
        end
        if (exp_ok) m_pass++; else m_fail++;
        cq.push_back('{ok: exp_ok, to: !do_done, pc: 16'(m_pass), fc: 16'(m_fail)});
        start = 1; len = LB'(l); base = b; step = s;
        @(negedge clk);
        start = inject; len = 2; base = 8'h77; step = 8'h11;
        for (int k = 0; k < l; k++) begin
            @(negedge clk);
            start = 0;
        end
        if (do_done) begin
            sum_done = 1; sum_result = res;
            @(negedge clk);
            sum_done = 0;
            chk("check_latency", {31'd0, check_valid}, 32'd1);
            chk("ready_turnaround", {31'd0, ready}, 32'd1);
        end else begin
            repeat (TMO - 1) @(negedge clk);
            chk("tmo_early", {31'd0, check_valid}, 32'd0);
            @(negedge clk);
            chk("tmo_fire", {31'd0, check_valid}, 32'd1);
            chk("tmo_ready", {31'd0, ready}, 32'd1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_ready", {31'd0, ready}, 32'd1);
        chk("reset_outs", {data_first, data_last, check_valid, check_ok, timeout, 19'd0, data_out}, 32'd0);
        chk("reset_cnt", {pass_cnt, fail_cnt}, 32'd0);
        rst_n = 1;
        @(negedge clk);

        run_series(4, 8'd1, 8'd1, 9'd10, 1, 1, 0);
        run_series(1, 8'h55, 8'd0, 9'h055, 1, 1, 0);
        run_series(3, 8'hC0, 8'h80, 9'h1C0, 1, 1, 0);
        run_series(3, 8'hFF, 8'd0, 9'h2FD, 1, 1, 0);
        run_series(4, 8'd1, 8'd1, 9'd9, 1, 0, 0);
        run_series(4, 8'd1, 8'd1, 9'd10, 1, 1, 1);

        // len = 0 start must leave everything untouched.
        wait_ready();
        start = 1; len = 0; base = 8'h12; step = 8'h01;
        @(negedge clk);
        start = 0;
        repeat (4) @(negedge clk);
        chk("len0_ready", {31'd0, ready}, 32'd1);
        chk("len0_cnt", {pass_cnt, fail_cnt}, {16'(m_pass), 16'(m_fail)});

        run_series(2, 8'd5, 8'd3, 9'd0, 0, 0, 0);

        // Reset while word 2 is on the bus.
        wait_ready();
        for (int k = 0; k < 3; k++) wq.push_back('{d: 8'(k + 1), f: (k == 0), l: 1'b0});
        start = 1; len = 4; base = 1; step = 1;
        @(negedge clk);
        start = 0;
        repeat (2) @(negedge clk);
        #2 rst_n = 0;
        #1;
        chk("rst_mid_ready", {31'd0, ready}, 32'd1);
        chk("rst_mid_outs", {data_first, data_last, check_valid, check_ok, timeout, 19'd0, data_out}, 32'd0);
        chk("rst_mid_cnt", {pass_cnt, fail_cnt}, 32'd0);
        m_pass = 0; m_fail = 0;
        repeat (2) @(negedge clk);
        #2 rst_n = 1;
        @(negedge clk);
        run_series(4, 8'd1, 8'd1, 9'd10, 1, 1, 0);

        repeat (3) @(negedge clk);
        chk("queues_empty", 32'(wq.size() + cq.size()), 32'd0);
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end
endmodule
